// File: rtl/rv32i_mmio_timer.sv
// Memory-mapped timer: prescaled 32-bit counter, compare match with optional reload, level IRQ.
// Optional input-capture channel is built when TIMER_CAPTURE_EN is defined.
module rv32i_mmio_timer #(
  parameter int XLEN     = 32,
  parameter int PORT_LEN = 32,
  parameter int ADDR_LSB = 2,
  parameter int ADDR_W   = 3
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                sel_i,
  input  logic                write_i,
  input  logic                read_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [PORT_LEN-1:0] data_i,
  input  logic                capture_i,
  output logic [PORT_LEN-1:0] data_o,
  output logic                irq_o
);

  localparam logic [ADDR_W-1:0] OFF_CTRL    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_STATUS  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_COUNT   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFF_COMPARE = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] OFF_CAPTURE = ADDR_W'(4);

  logic                r_en, r_reload, r_irqen;
  logic [7:0]          r_presc, r_psc;
  logic [PORT_LEN-1:0] r_count, r_compare;
  logic                r_match, r_ovf;

  logic [ADDR_W-1:0]   w_off;
  logic                w_wr, w_wr_ctrl, w_wr_status, w_wr_count, w_wr_compare;
  logic                w_tick, w_hit, w_set_ovf;
  logic                w_cap_flag;
  logic [PORT_LEN-1:0] w_capture;
  logic [PORT_LEN-1:0] w_rdata;
  logic                w_unused;

  assign w_off        = addr_i[ADDR_LSB+ADDR_W-1:ADDR_LSB];
  assign w_wr         = sel_i & write_i;
  assign w_wr_ctrl    = w_wr & (w_off == OFF_CTRL);
  assign w_wr_status  = w_wr & (w_off == OFF_STATUS);
  assign w_wr_count   = w_wr & (w_off == OFF_COUNT);
  assign w_wr_compare = w_wr & (w_off == OFF_COMPARE);

  // Match is judged on the pre-write COUNT; a reload match takes precedence over the wrap.
  assign w_tick    = r_en & (r_psc == r_presc);
  assign w_hit     = w_tick & (r_count == r_compare);
  assign w_set_ovf = w_tick & (&r_count) & ~(w_hit & r_reload);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_en     <= 1'b0;
      r_reload <= 1'b0;
      r_irqen  <= 1'b0;
      r_presc  <= 8'd0;
    end else if (w_wr_ctrl) begin
      r_en     <= data_i[0];
      r_reload <= data_i[1];
      r_irqen  <= data_i[2];
      r_presc  <= data_i[15:8];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)      r_psc <= 8'd0;
    else if (w_wr_ctrl) r_psc <= 8'd0;
    else if (r_en)      r_psc <= w_tick ? 8'd0 : r_psc + 8'd1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)       r_count <= '0;
    else if (w_wr_count) r_count <= data_i;
    else if (w_tick)     r_count <= (w_hit & r_reload) ? '0 : r_count + PORT_LEN'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)         r_compare <= '0;
    else if (w_wr_compare) r_compare <= data_i;
  end

  // Hardware set beats a simultaneous write-one-to-clear.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_match <= w_hit     | (r_match & ~(w_wr_status & data_i[0]));
      r_ovf   <= w_set_ovf | (r_ovf   & ~(w_wr_status & data_i[1]));
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic                r_sync1, r_sync2, r_sync3;
  logic                r_cap;
  logic [PORT_LEN-1:0] r_capture;
  logic                w_cap_rise;

  assign w_cap_rise = r_sync2 & ~r_sync3;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_cap     <= 1'b0;
      r_capture <= '0;
    end else begin
      r_sync1 <= capture_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_cap   <= w_cap_rise | (r_cap & ~(w_wr_status & data_i[2]));
      if (w_cap_rise) r_capture <= r_count;
    end
  end

  assign w_cap_flag = r_cap;
  assign w_capture  = r_capture;
  assign w_unused   = ^{addr_i[XLEN-1:ADDR_LSB+ADDR_W], addr_i[ADDR_LSB-1:0]};
`else
  assign w_cap_flag = 1'b0;
  assign w_capture  = '0;
  assign w_unused   = ^{addr_i[XLEN-1:ADDR_LSB+ADDR_W], addr_i[ADDR_LSB-1:0], capture_i};
`endif

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL: begin
        w_rdata[0]    = r_en;
        w_rdata[1]    = r_reload;
        w_rdata[2]    = r_irqen;
        w_rdata[15:8] = r_presc;
      end
      OFF_STATUS: begin
        w_rdata[0] = r_match;
        w_rdata[1] = r_ovf;
        w_rdata[2] = w_cap_flag;
      end
      OFF_COUNT:   w_rdata = r_count;
      OFF_COMPARE: w_rdata = r_compare;
      OFF_CAPTURE: w_rdata = w_capture;
      default:     w_rdata = '0;
    endcase
  end

  assign data_o = (sel_i & read_i) ? w_rdata : '0;
  assign irq_o  = r_irqen & (r_match | r_ovf | w_cap_flag);

endmodule
